// File: rtl/cla_nibble_seq_if.sv
// Request/response channel of the nibble-serial adder: operands in on the
// request side, result plus flags out on the response side.
interface cla_nibble_seq_if #(
    parameter int WIDTH = 16
) ();
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output req_valid, a, b, cin, sub, rsp_ready,
        input  req_ready, rsp_valid, sum, cout, ovf
    );

    modport slave (
        input  req_valid, a, b, cin, sub, rsp_ready,
        output req_ready, rsp_valid, sum, cout, ovf
    );
endinterface

// File: rtl/cla_nibble_seq.sv
// WIDTH-bit add/subtract built from one 4-bit carry-lookahead slice that is
// reused once per nibble, LSB first, with the carry held between steps.
module cla_nibble_seq #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    cla_nibble_seq_if.slave    bus,
    output logic               busy
);
    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_r, b_r, sum_r;
    logic             carry, cout_r, ovf_r;
    logic [IDXW-1:0]  idx;

    logic [3:0] nib_a, nib_b, g, p, s;
    logic [4:0] c;
    logic       last;

    // Select the active nibble of each operand.
    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int unsigned i = 0; i < NIB; i++) begin
            if (idx == IDXW'(i)) begin
                nib_a = a_r[4*i +: 4];
                nib_b = b_r[4*i +: 4];
            end
        end
    end

    always_comb begin
        g    = nib_a & nib_b;
        p    = nib_a ^ nib_b;
        c[0] = carry;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        s    = p ^ c[3:0];
        last = (idx == IDXW'(NIB - 1));
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.req_valid) state_nx = RUN;
            RUN:     if (last)          state_nx = DONE;
            DONE:    if (bus.rsp_ready) state_nx = IDLE;
            default:                    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_r    <= '0;
            b_r    <= '0;
            sum_r  <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
            idx    <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        a_r   <= bus.a;
                        b_r   <= bus.sub ? ~bus.b : bus.b;
                        carry <= bus.sub | bus.cin;
                        idx   <= '0;
                        sum_r <= '0;
                    end
                end
                RUN: begin
                    for (int unsigned i = 0; i < NIB; i++) begin
                        if (idx == IDXW'(i)) sum_r[4*i +: 4] <= s;
                    end
                    carry <= c[4];
                    idx   <= idx + 1'b1;
                    if (last) begin
                        cout_r <= c[4];
                        ovf_r  <= c[3] ^ c[4];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = (state == DONE);
    assign bus.sum       = sum_r;
    assign bus.cout      = cout_r;
    assign bus.ovf       = ovf_r;
    assign busy          = (state != IDLE);
endmodule

// File: doc/cla_nibble_seq.md
Name: cla_nibble_seq

Overview:
- Sequencer that performs WIDTH-bit add/subtract by time-multiplexing one internal 4-bit carry-lookahead adder slice, one nibble per cycle, LSB nibble first.
- Carry is held in a register between nibbles.
- Sits between an operand producer (valid/ready request channel) and a result consumer (valid/ready response channel).
- Used where a full-width adder is too large and per-nibble latency is acceptable.

Parameters:
- WIDTH, 16, operand/result width; multiple of 4, minimum 4.
- NIB, WIDTH/4 (derived, not overridable), number of nibble steps.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- req_valid  input  1  operands valid
- req_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in (add mode only)
- sub  input  1  1 = A - B, 0 = A + B + cin
- rsp_valid  output  1  result valid
- rsp_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- cout  output  1  carry out of MSB (subtract: 1 = no borrow)
- ovf  output  1  signed two's-complement overflow
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst=1 at a clk edge): state←IDLE; sum, cout, ovf, rsp_valid←0; internal operand, carry and nibble-index registers←0. Applies from any state; an in-flight operation is discarded with no response.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - req_ready=1, busy=0.
  - On req_valid=1, latch a→A_r and (sub ? ~b : b)→B_r; carry←(sub ? 1 : cin); idx←0; sum←0; go to RUN.
- RUN:
  - req_ready=0, busy=1.
  - Each cycle: slice computes A_r[4*idx+:4] + B_r[4*idx+:4] + carry; result written to sum[4*idx+:4]; carry←slice carry-out; idx←idx+1.
  - At idx==NIB-1: cout←slice carry-out; ovf←(carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1); go to DONE.
  - sum bits of nibbles not yet processed read 0 during RUN.
- DONE:
  - rsp_valid=1; sum/cout/ovf held stable.
  - On rsp_ready=1, go to IDLE next cycle with rsp_valid←0. sum/cout/ovf keep their values until the next accept.
  - Stays in DONE indefinitely while rsp_ready=0.
- Latency: operands accepted at edge T; rsp_valid first high after edge T+NIB (NIB RUN cycles). Throughput: one operation per NIB+2 cycles minimum (accept, NIB RUN, DONE handshake). No overlap; req_ready=0 from accept until return to IDLE.
- Input timing: req_valid/a/b/cin/sub are ignored outside IDLE. Inputs may change freely after the accept edge.
- Arithmetic: modulo 2^WIDTH.
  - Subtract = A + ~B + 1; cin ignored when sub=1.
  - ovf computed identically for add and subtract using the effective operands.
- WIDTH=4: NIB=1; RUN lasts exactly one cycle.
- Simultaneous rsp_ready and a new req_valid in DONE: the response completes; the new request is not accepted until IDLE (next cycle).

Test Plan:
- WIDTH=16, add 0x1234+0x4321, cin=0 -> sum=0x5555, cout=0, ovf=0; rsp_valid rises exactly 4 cycles after the accept edge.
- Add 0xFFFF+0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; carry ripples through all 4 nibble steps.
- Add 0x7FFF+0x0000, cin=1 -> sum=0x8000, cout=0, ovf=1. Add 0x8000+0x8000 -> sum=0x0000, cout=1, ovf=1.
- Subtract with cin=1 (must be ignored):
  - 0x0005-0x0007 -> sum=0xFFFE, cout=0, ovf=0.
  - 0x8000-0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- Backpressure: hold rsp_ready=0 for 10 cycles with req_valid=1 and changing a/b -> req_ready=0 throughout; sum/cout/ovf stable; on rsp_ready=1, IDLE next cycle; next request then accepted.
- Assert rst for one cycle during RUN at idx=2 -> next cycle state IDLE, rsp_valid=0, sum=0, req_ready=1; a following 0x0001+0x0001 yields 0x0002 with no carry leakage from the aborted operation.
